// File: rtl/rf_pkg.sv
// Shared definitions for the register-file arbiter: access-type encoding and FSM states.
package rf_pkg;

    localparam logic RF_RD = 1'b0;
    localparam logic RF_WR = 1'b1;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N-1.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          found
);

    always_comb begin
        int c;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            // Explicit wrap so a non-power-of-two N never yields an out-of-range index.
            c = int'(ptr) + k;
            if (c >= N) c = c - N;
            if (!found && req[c]) begin
                grant[c] = 1'b1;
                idx      = PW'(c);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_arbiter.sv
// Round-robin arbiter sharing one single-port register file among NREQ requesters,
// with a lock that lets one requester hold the port across a multi-access sequence.
module rf_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ-1:0]   req_lock,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rf_we,
    output logic [AW-1:0]     rf_addr,
    output logic [DW-1:0]     rf_din,
    input  logic [DW-1:0]     rf_dout
);

    localparam int PW = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   owner_q, owner_d;

    logic [NREQ-1:0] cand;
    logic [PW-1:0]   pick_ptr;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   win;
    logic            found;
    logic            accept;

    logic            sel_we;
    logic            sel_lock;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    logic [NREQ-1:0] rsp_vld_p1;
    logic [DW-1:0]   rsp_data_p1;

    // While locked, only the owner is a candidate; starting the search at the owner finds it directly.
    always_comb begin
        cand     = req_valid;
        pick_ptr = rr_ptr_q;
        if (state_q == ST_LOCKED) begin
            cand     = req_valid & (NREQ'(1) << owner_q);
            pick_ptr = owner_q;
        end
    end

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req   (cand),
        .ptr   (pick_ptr),
        .grant (grant),
        .idx   (win),
        .found (found)
    );

    assign accept = found & ~rst;

    always_comb begin
        sel_we    = RF_RD;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_we    = req_we[i];
                sel_lock  = req_lock[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    // Stage p0: combinational grant and regfile drive in the accept cycle.
    assign req_ready = accept ? grant : '0;
    assign rf_we     = accept & (sel_we == RF_WR);
    assign rf_addr   = accept ? sel_addr : '0;
    assign rf_din    = accept ? sel_wdata : '0;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (state_q == ST_ARB) begin
                rr_ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
                if (sel_lock) begin
                    state_d = ST_LOCKED;
                    owner_d = win;
                end
            end else if (!sel_lock) begin
                state_d = ST_ARB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ARB;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            rsp_vld_p1  <= '0;
            rsp_data_p1 <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            rsp_vld_p1 <= req_ready;
            if (accept) begin
                rsp_data_p1 <= (sel_we == RF_RD) ? rf_dout : sel_wdata;
            end
        end
    end

    // Stage p1: registered response; a response pending when rst rises is suppressed.
    assign rsp_valid = rst ? '0 : rsp_vld_p1;
    assign rsp_rdata = rst ? '0 : rsp_data_p1;

endmodule

// File: tb/tb_rf_arbiter.sv
// Scoreboard bench for rf_arbiter: NREQ=4 instance with a regfile model, plus an NREQ=3 instance for pointer wrap.
module tb_rf_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  rv, rwe, rlk, rdy, rspv;
    logic [31:0] raddr, rwd;
    logic [7:0]  rspd, rfaddr, rfdin, rfdout;
    logic        rfwe;

    logic [2:0]  bv, bwe, blk, brdy, brspv;
    logic [23:0] baddr, bwd;
    logic [7:0]  brspd, brfaddr, brfdin;
    logic [7:0]  bdout;
    logic        brfwe;

    logic [7:0] mem [256];

    rf_arbiter #(.NREQ(4), .DW(8), .DEPTH(256)) dut_a (
        .clk(clk), .rst(rst), .req_valid(rv), .req_we(rwe), .req_lock(rlk),
        .req_addr(raddr), .req_wdata(rwd), .req_ready(rdy), .rsp_valid(rspv),
        .rsp_rdata(rspd), .rf_we(rfwe), .rf_addr(rfaddr), .rf_din(rfdin), .rf_dout(rfdout)
    );

    rf_arbiter #(.NREQ(3), .DW(8), .DEPTH(256)) dut_b (
        .clk(clk), .rst(rst), .req_valid(bv), .req_we(bwe), .req_lock(blk),
        .req_addr(baddr), .req_wdata(bwd), .req_ready(brdy), .rsp_valid(brspv),
        .rsp_rdata(brspd), .rf_we(brfwe), .rf_addr(brfaddr), .rf_din(brfdin), .rf_dout(bdout)
    );

    // Regfile model: combinational read, write commits at the clock edge.
    initial for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
    always @(posedge clk) if (rfwe) mem[rfaddr] <= rfdin;
    assign rfdout = mem[rfaddr];

    typedef struct {
        int         who;
        logic [7:0] d;
        int         at;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(int i, bit v, bit we, bit lk, logic [7:0] a, logic [7:0] d);
        rv[i] = v;
        rwe[i] = we;
        rlk[i] = lk;
        raddr[i*8 +: 8] = a;
        rwd[i*8 +: 8] = d;
    endtask

    task automatic pusha(int who, logic [7:0] d);
        qa.push_back('{who: who, d: d, at: cyc_n + 1});
    endtask

    task automatic pushb(int who, logic [7:0] d);
        qb.push_back('{who: who, d: d, at: cyc_n + 1});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rspv != 4'b0) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_rsp", 32'(rspv), 32'h0);
            end else begin
                e = qa.pop_front();
                chk("a_rsp_valid", 32'(rspv), 32'(1) << e.who);
                chk("a_rsp_rdata", 32'(rspd), 32'(e.d));
                chk("a_rsp_cycle", 32'(cyc_n), 32'(e.at));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (brspv != 3'b0) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_rsp", 32'(brspv), 32'h0);
            end else begin
                e = qb.pop_front();
                chk("b_rsp_valid", 32'(brspv), 32'(1) << e.who);
                chk("b_rsp_rdata", 32'(brspd), 32'(e.d));
                chk("b_rsp_cycle", 32'(cyc_n), 32'(e.at));
            end
        end
    end

    int         g_seq [5] = '{0, 1, 2, 3, 0};
    logic [7:0] d_seq [5] = '{8'h1C, 8'h1D, 8'h1E, 8'h1F, 8'h1C};

    initial begin
        rst = 1'b1;
        rv = '0; rwe = '0; rlk = '0; raddr = '0; rwd = '0;
        bv = '0; bwe = '0; blk = '0; baddr = '0; bwd = '0;
        bdout = 8'hC3;
        put(0, 1, 1, 0, 8'h10, 8'hA5);

        // Reset: request present but nothing granted.
        tick; #2;
        chk("rst_ready", 32'(rdy), 32'h0);
        chk("rst_rsp_valid", 32'(rspv), 32'h0);
        chk("rst_rsp_rdata", 32'(rspd), 32'h0);
        chk("rst_rf_we", 32'(rfwe), 32'h0);
        chk("rst_b_ready", 32'(brdy), 32'h0);

        // Write 0x10 <= 0xA5 from req0, then read it back from req3.
        tick; rst = 1'b0; #2;
        chk("wr_ready", 32'(rdy), 32'h1);
        chk("wr_rf_we", 32'(rfwe), 32'h1);
        chk("wr_rf_addr", 32'(rfaddr), 32'h10);
        chk("wr_rf_din", 32'(rfdin), 32'hA5);
        pusha(0, 8'hA5);

        tick; put(0, 0, 0, 0, 8'h00, 8'h00); put(3, 1, 0, 0, 8'h10, 8'h00); #2;
        chk("raw_ready", 32'(rdy), 32'h8);
        chk("raw_rf_we", 32'(rfwe), 32'h0);
        chk("raw_rf_addr", 32'(rfaddr), 32'h10);
        pusha(3, 8'hA5);

        // All four read continuously from rr_ptr=0.
        for (int k = 0; k < 5; k++) begin
            tick;
            if (k == 0) for (int i = 0; i < 4; i++) put(i, 1, 0, 0, 8'(8'h20 + i), 8'h00);
            #2;
            chk("rr_ready", 32'(rdy), 32'(1) << g_seq[k]);
            pusha(g_seq[k], d_seq[k]);
        end

        // Lock by req1 (read, then write releasing the lock) with req0/req2 waiting.
        tick; rv = '0;
        put(0, 1, 0, 0, 8'h31, 8'h00); put(1, 1, 0, 1, 8'h30, 8'h00); put(2, 1, 0, 0, 8'h32, 8'h00); #2;
        chk("lk_first_ready", 32'(rdy), 32'h2);
        pusha(1, 8'h0C);
        tick; put(1, 1, 1, 0, 8'h30, 8'h77); #2;
        chk("lk_hold_ready", 32'(rdy), 32'h2);
        chk("lk_hold_rf_we", 32'(rfwe), 32'h1);
        pusha(1, 8'h77);
        tick; put(1, 0, 0, 0, 8'h00, 8'h00); #2;
        chk("lk_release_ready", 32'(rdy), 32'h4);
        pusha(2, 8'h0E);
        tick; put(2, 0, 0, 0, 8'h00, 8'h00); #2;
        chk("lk_next_ready", 32'(rdy), 32'h1);
        pusha(0, 8'h0D);

        // Lock owner req3 goes idle for three cycles; others must stall.
        tick; rv = '0; put(3, 1, 0, 1, 8'h40, 8'h00); #2;
        chk("idle_lock_ready", 32'(rdy), 32'h8);
        pusha(3, 8'h7C);
        for (int k = 0; k < 3; k++) begin
            tick;
            if (k == 0) begin
                put(3, 0, 0, 0, 8'h00, 8'h00);
                put(0, 1, 0, 0, 8'h50, 8'h00);
                put(1, 1, 0, 0, 8'h51, 8'h00);
            end
            #2;
            chk("idle_stall_ready", 32'(rdy), 32'h0);
            chk("idle_stall_rf_we", 32'(rfwe), 32'h0);
        end
        tick; put(3, 1, 0, 0, 8'h41, 8'h00); #2;
        chk("idle_resume_ready", 32'(rdy), 32'h8);
        pusha(3, 8'h7D);
        tick; put(3, 0, 0, 0, 8'h00, 8'h00); #2;
        chk("idle_after0_ready", 32'(rdy), 32'h1);
        pusha(0, 8'h6C);
        tick; put(0, 0, 0, 0, 8'h00, 8'h00); #2;
        chk("idle_after1_ready", 32'(rdy), 32'h2);
        pusha(1, 8'h6D);

        // Reset right after a read accept drops its response.
        tick; put(1, 0, 0, 0, 8'h00, 8'h00); put(2, 1, 0, 0, 8'h60, 8'h00); #2;
        chk("rr_drop_accept_ready", 32'(rdy), 32'h4);
        tick; rst = 1'b1;
        put(2, 0, 0, 0, 8'h00, 8'h00); put(0, 1, 0, 0, 8'h50, 8'h00); put(1, 1, 0, 0, 8'h51, 8'h00); #2;
        chk("rd_rst_ready", 32'(rdy), 32'h0);
        chk("rd_rst_rsp_valid", 32'(rspv), 32'h0);
        chk("rd_rst_rf_we", 32'(rfwe), 32'h0);
        tick; rst = 1'b0; #2;
        chk("post_rst_ready", 32'(rdy), 32'h1);
        pusha(0, 8'h6C);
        tick; rv = '0; #2;
        chk("idle_ready", 32'(rdy), 32'h0);
        chk("idle_rf_addr", 32'(rfaddr), 32'h0);

        // NREQ=3: only req2 valid; pointer wraps 2 -> 0 and req2 keeps winning.
        for (int k = 0; k < 5; k++) begin
            tick;
            if (k == 0) begin
                bv = 3'b100;
                baddr[16 +: 8] = 8'h05;
            end
            #2;
            chk("b_wrap_ready", 32'(brdy), 32'h4);
            chk("b_wrap_rf_addr", 32'(brfaddr), 32'h05);
            chk("b_wrap_rf_we", 32'(brfwe), 32'h0);
            chk("b_wrap_rf_din", 32'(brfdin), 32'h0);
            pushb(2, 8'hC3);
        end
        tick; bv = '0;
        repeat (4) tick;

        chk("a_pending_rsp", 32'(qa.size()), 32'h0);
        chk("b_pending_rsp", 32'(qb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
